// File: rtl/mux_route.sv
// rtl/mux_route.sv - routes popped input-FIFO words to the output FIFO named by their destination field
// Optional per-destination word counters are built only when WORD_COUNT_EN is defined.
module mux_route #(
   parameter int DATA_WIDTH = 6,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [3:0]            pop,
   input  logic [DATA_WIDTH-1:0] data_in0,
   input  logic [DATA_WIDTH-1:0] data_in1,
   input  logic [DATA_WIDTH-1:0] data_in2,
   input  logic [DATA_WIDTH-1:0] data_in3,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [3:0]            push_out,
   output logic                  valid_out,
   output logic [1:0]            src_out,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  count0,
   output logic [CNT_WIDTH-1:0]  count1,
   output logic [CNT_WIDTH-1:0]  count2,
   output logic [CNT_WIDTH-1:0]  count3
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ERR} state_t;

   state_t                  state;
   logic [3:0]              pop_q;
   logic                    pop_one;
   logic                    pop_multi;
   logic                    pop_q_one;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [1:0]              sel_src;

   always_comb begin
      pop_one   = (pop != 4'b0) && ((pop & (pop - 4'd1)) == 4'b0);
      pop_multi = (pop != 4'b0) && !pop_one;
      pop_q_one = (pop_q != 4'b0) && ((pop_q & (pop_q - 4'd1)) == 4'b0);
      sel_data  = data_in0;
      sel_src   = 2'd0;
      case (pop_q)
         4'b0010: begin sel_data = data_in1; sel_src = 2'd1; end
         4'b0100: begin sel_data = data_in2; sel_src = 2'd2; end
         4'b1000: begin sel_data = data_in3; sel_src = 2'd3; end
         default: begin sel_data = data_in0; sel_src = 2'd0; end
      endcase
   end

   // The output stage only looks at pop_q, so a word already in flight is
   // emitted even on the edge where a multi-hot pop moves the FSM to S_ERR.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= S_IDLE;
         pop_q     <= 4'b0;
         data_out  <= '0;
         push_out  <= 4'b0;
         valid_out <= 1'b0;
         src_out   <= 2'd0;
         err       <= 1'b0;
      end else begin
         valid_out <= pop_q_one;
         push_out  <= pop_q_one ? (4'b0001 << sel_data[DATA_WIDTH-1 -: 2]) : 4'b0;
         if (pop_q_one) begin
            data_out <= sel_data;
            src_out  <= sel_src;
         end
         case (state)
            S_IDLE, S_FETCH: begin
               if (pop_multi) begin
                  state <= S_ERR;
                  err   <= 1'b1;
                  pop_q <= 4'b0;
               end else begin
                  state <= pop_one ? S_FETCH : S_IDLE;
                  pop_q <= pop;
               end
            end
            S_ERR: begin
               pop_q <= 4'b0;
               if (err_clr) begin
                  state <= S_IDLE;
                  err   <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               pop_q <= 4'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

`ifdef WORD_COUNT_EN
   logic [CNT_WIDTH-1:0] cnt [4];

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int d = 0; d < 4; d++) cnt[d] <= '0;
      end else begin
         for (int d = 0; d < 4; d++) begin
            if (push_out[d] && (cnt[d] != {CNT_WIDTH{1'b1}})) cnt[d] <= cnt[d] + 1'b1;
         end
      end
   end

   assign count0 = cnt[0];
   assign count1 = cnt[1];
   assign count2 = cnt[2];
   assign count3 = cnt[3];
`else
   assign count0 = '0;
   assign count1 = '0;
   assign count2 = '0;
   assign count3 = '0;
`endif

endmodule

// File: tb/tb_mux_route.sv
// tb/tb_mux_route.sv - randomized and directed checks of mux_route against a word-level reference model
// Expected counter values follow WORD_COUNT_EN the same way the design does.
module tb_mux_route;
   localparam int DW = 6;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic [3:0]    pop = 4'b0;
   logic [DW-1:0] din [4];
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_out;
   logic [3:0]    push_out;
   logic          valid_out;
   logic [1:0]    src_out;
   logic          err;
   logic [CW-1:0] count0, count1, count2, count3;

   int checks = 0;
   int errors = 0;

   mux_route #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_L(reset_L), .pop(pop),
      .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
      .err_clr(err_clr), .data_out(data_out), .push_out(push_out),
      .valid_out(valid_out), .src_out(src_out), .err(err),
      .count0(count0), .count1(count1), .count2(count2), .count3(count3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word is accepted when a one-hot pop arrives while no
   // error is pending; it appears at the outputs one clock after its data is read.
   bit            m_err;
   bit            acc_v;
   int            acc_k;
   bit            e_valid;
   logic [DW-1:0] e_data;
   logic [1:0]    e_src;
   logic [3:0]    e_push;
   int            e_cnt [4];
   bit            cmp_en = 1'b0;

   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         m_err = 0; acc_v = 0; acc_k = 0;
         e_valid = 0; e_data = '0; e_src = 2'd0; e_push = 4'b0;
         for (int d = 0; d < 4; d++) e_cnt[d] = 0;
      end else begin
`ifdef WORD_COUNT_EN
         for (int d = 0; d < 4; d++) if (e_push[d] && e_cnt[d] < (2**CW) - 1) e_cnt[d]++;
`endif
         if (acc_v) begin
            e_valid = 1;
            e_data  = din[acc_k];
            e_src   = 2'(acc_k);
            e_push  = 4'b0001 << e_data[DW-1:DW-2];
         end else begin
            e_valid = 0;
            e_push  = 4'b0;
         end
         acc_v = !m_err && ($countones(pop) == 1);
         for (int b = 0; b < 4; b++) if (pop[b]) acc_k = b;
         if (!m_err && $countones(pop) > 1) m_err = 1;
         else if (m_err && err_clr) m_err = 0;
      end
   end

   always @(negedge clk) begin
      if (reset_L && cmp_en) begin
         chk("valid_out", 32'(valid_out), 32'(e_valid));
         chk("push_out", 32'(push_out), 32'(e_push));
         chk("data_out", 32'(data_out), 32'(e_data));
         chk("src_out", 32'(src_out), 32'(e_src));
         chk("err", 32'(err), 32'(m_err));
         chk("count0", 32'(count0), 32'(e_cnt[0]));
         chk("count1", 32'(count1), 32'(e_cnt[1]));
         chk("count2", 32'(count2), 32'(e_cnt[2]));
         chk("count3", 32'(count3), 32'(e_cnt[3]));
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) din[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_push", 32'(push_out), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_err", 32'(err), 0);
      #1 reset_L = 1'b1;
      cmp_en = 1'b1;

      // single word: source 0, destination 2
      @(negedge clk); pop = 4'b0001;
      @(negedge clk); pop = 4'b0000; din[0] = 6'b100101;
      @(negedge clk);
      chk("single_valid", 32'(valid_out), 1);
      chk("single_data", 32'(data_out), 32'h25);
      chk("single_push", 32'(push_out), 32'h4);
      chk("single_src", 32'(src_out), 0);
      @(negedge clk);
      chk("single_valid_off", 32'(valid_out), 0);
      chk("single_push_off", 32'(push_out), 0);
      chk("single_data_hold", 32'(data_out), 32'h25);

      // back-to-back pops from every source, destinations 3..0
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pop = (i < 4) ? (4'b0001 << i) : 4'b0000;
         if (i >= 1 && i <= 4) din[i-1] = {2'(4 - i), 4'hA};
         if (i >= 2) begin
            chk("b2b_valid", 32'(valid_out), 1);
            chk("b2b_push", 32'(push_out), 32'(4'b1000 >> (i - 2)));
            chk("b2b_src", 32'(src_out), 32'(i - 2));
         end
      end

      // multi-hot pop with a word in flight
      @(negedge clk); pop = 4'b0001;
      @(negedge clk); pop = 4'b0011; din[0] = 6'b010000;
      @(negedge clk); pop = 4'b0100;
      chk("err_inflight_valid", 32'(valid_out), 1);
      chk("err_inflight_push", 32'(push_out), 32'h2);
      chk("err_set", 32'(err), 1);
      @(negedge clk); pop = 4'b1000;
      chk("err_nopush1", 32'(push_out), 0);
      @(negedge clk); pop = 4'b0001;
      chk("err_nopush2", 32'(push_out), 0);
      @(negedge clk); pop = 4'b0000; err_clr = 1'b1;
      chk("err_sticky", 32'(err), 1);
      chk("err_nopush3", 32'(push_out), 0);
      @(negedge clk); err_clr = 1'b0; pop = 4'b0100;
      chk("err_cleared", 32'(err), 0);
      @(negedge clk); pop = 4'b0000; din[2] = 6'b011111;
      @(negedge clk);
      chk("after_clr_push", 32'(push_out), 32'h2);
      chk("after_clr_src", 32'(src_out), 2);
      chk("after_clr_data", 32'(data_out), 32'h1F);

      // reset with a word in flight
      @(negedge clk); pop = 4'b0010;
      @(negedge clk); pop = 4'b0000;
      #2 reset_L = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_out), 0);
      chk("arst_push", 32'(push_out), 0);
      chk("arst_data", 32'(data_out), 0);
      chk("arst_count1", 32'(count1), 0);
      @(negedge clk); #1 reset_L = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("arst_no_push", 32'(push_out), 0);
         chk("arst_count1_hold", 32'(count1), 0);
      end

      // 260 words to destination 2: counter saturation
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         pop = 4'b0001 << $urandom_range(0, 3);
         for (int s = 0; s < 4; s++) din[s] = {2'b10, 4'($urandom)};
      end
      @(negedge clk); pop = 4'b0000;
      repeat (4) @(negedge clk);
`ifdef WORD_COUNT_EN
      chk("sat_count2", 32'(count2), 255);
`else
      chk("sat_count2", 32'(count2), 0);
`endif
      chk("sat_count0", 32'(count0), 0);
      chk("sat_count3", 32'(count3), 0);

      // randomized traffic, including multi-hot pops and stray err_clr
      for (int i = 0; i < 3000; i++) begin
         int r;
         @(negedge clk);
         r = $urandom_range(0, 19);
         if (r < 12) pop = 4'b0001 << $urandom_range(0, 3);
         else if (r < 18) pop = 4'b0000;
         else pop = (4'b0001 << $urandom_range(0, 1)) | (4'b0100 << $urandom_range(0, 1));
         err_clr = ($urandom_range(0, 7) == 0);
         for (int s = 0; s < 4; s++) din[s] = DW'($urandom);
      end
      @(negedge clk); pop = 4'b0000; err_clr = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux_route.md
MUX_ROUTE -- requirements
Module: mux_route

Interface
REQ-001 Parameter DATA_WIDTH, default 6: word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] of each word are the 2-bit destination.
REQ-002 Parameter CNT_WIDTH, default 8: width of each per-destination word counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 pop  input  4  one-hot pop issued by the upstream arbiter to the four input FIFOs.
REQ-006 data_in0..data_in3  input  DATA_WIDTH each  read data of input FIFOs 0..3; valid the cycle after the matching pop bit.
REQ-007 err_clr  input  1  synchronous clear of the error state.
REQ-008 data_out  output  DATA_WIDTH  routed word, shared by the four output FIFOs.
REQ-009 push_out  output  4  one-hot push to output FIFO selected by the destination field.
REQ-010 valid_out  output  1  data_out/push_out carry a word this cycle.
REQ-011 src_out  output  2  index of the input FIFO the current word came from.
REQ-012 err  output  1  sticky protocol error (pop not one-hot).
REQ-013 count0..count3  output  CNT_WIDTH each  words pushed to output FIFOs 0..3.

Function
REQ-014 The block SHALL register pop into pop_q each cycle (pop_q forced to 0 in S_ERR).
REQ-015 In the cycle where pop_q is one-hot with bit k set, it SHALL select data_in_k; at the next rising edge it SHALL register data_out=data_in_k, src_out=k, valid_out=1.
REQ-016 Latency: pop asserted in cycle t SHALL yield valid_out=1 in cycle t+2; back-to-back pops SHALL yield back-to-back valid_out with no bubbles.
REQ-017 push_out SHALL be registered together with data_out: push_out[d]=1 for d = data_in_k[DATA_WIDTH-1:DATA_WIDTH-2], all other bits 0; push_out SHALL be 0 whenever valid_out=0.
REQ-018 When pop_q=0, valid_out and push_out SHALL be 0 next cycle; data_out and src_out SHALL hold their last value.
REQ-019 FSM states: S_IDLE (no word in flight), S_FETCH (word in flight), S_ERR.
REQ-020 S_IDLE: pop one-hot -> S_FETCH; pop=0 -> S_IDLE; pop with 2+ bits set -> S_ERR.
REQ-021 S_FETCH: pop one-hot -> S_FETCH; pop=0 -> S_IDLE; pop with 2+ bits set -> S_ERR. The word already in flight SHALL still be emitted.
REQ-022 S_ERR: err=1, no new words accepted, push_out=0; err_clr=1 -> S_IDLE with err=0 next cycle; otherwise stay.
REQ-023 err_clr outside S_ERR SHALL have no effect.
REQ-024 A multi-hot pop SHALL never produce a push.

Reset
REQ-025 reset_L=0 SHALL immediately force state=S_IDLE, pop_q=0, data_out=0, push_out=0, valid_out=0, src_out=0, err=0, count0..count3=0.
REQ-026 Reset asserted with a word in flight SHALL discard it; no push after reset release until a new pop.

Configuration
REQ-027 Macro WORD_COUNT_EN: when defined, countd SHALL increment by 1 on each cycle push_out[d]=1 and saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-028 When WORD_COUNT_EN is not defined, count0..count3 SHALL be constant 0 and no counter registers SHALL exist; all other behaviour is unchanged.

Verification
REQ-029 Single pop=0001, data_in0=6'b10_0101 next cycle -> two cycles after pop: valid_out=1, data_out=6'b100101, push_out=0100, src_out=0, for one cycle.
REQ-030 pops 0001,0010,0100,1000 on consecutive cycles, dest fields 3,2,1,0 -> four consecutive valid_out cycles, push_out 1000,0100,0010,0001, src_out 0,1,2,3.
REQ-031 pop=0011 while a word is in flight -> in-flight word emitted, then err=1, no further pushes despite pops; err_clr=1 one cycle -> err=0, next pop=0100 routed normally.
REQ-032 reset_L deasserted asynchronously one cycle after pop=0010 -> outputs 0 immediately, no push after release, count1 unchanged.
REQ-033 With WORD_COUNT_EN, CNT_WIDTH=8: 260 words with dest 2 -> count2=255, others 0; without macro all counts 0.
